// File: rtl/pong_match_controller.sv
// pong_match_controller
//   Match-level sequencer for Pong. It gates the ball logic (run/respawn),
//   keeps both scores, chooses the serve direction, handles pause and
//   declares the winner.
// Ports
//   CLOCK_25     in   pixel clock
//   reset        in   async active-high reset
//   frame_tick   in   one pulse per video frame
//   start_btn    in   raw asynchronous start button (level)
//   pause_pulse  in   sync pulse, toggles pause in SERVE/RALLY
//   miss_p1/p2   in   sync pulses from the ball logic (p1 miss -> p2 scores)
//   ball_run     out  ball may advance
//   ball_respawn out  one-cycle pulse on every entry into SERVE
//   serve_left   out  serve direction (1 = toward player 1)
//   score_p1/p2  out  4-bit scores, saturate at WIN_SCORE
//   winner       out  00 none, 01 p1, 10 p2
//   state_o      out  state encoding
//   paused       out  pause active
module pong_match_controller #(
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_HOLD_FRAMES  = 90
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_pulse,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic       ball_run,
  output logic       ball_respawn,
  output logic       serve_left,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state_o,
  output logic       paused
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN4   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE8 = 8'(SERVE_DELAY_FRAMES);
  localparam logic [7:0] HOLD8  = 8'(POINT_HOLD_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] sc1_q, sc1_d, sc2_q, sc2_d;
  logic [1:0] win_q, win_d;
  logic       srv_q, srv_d;
  logic       pse_q, pse_d;
  logic       run_q, run_d;
  logic       rsp_q, rsp_d;
  // start_btn: two synchroniser flops plus a history flop for edge detect
  logic       st1_q, st2_q, st3_q;
  logic       start_evt;
  logic       count_en;

  assign start_evt = st2_q & ~st3_q;
  // A tick only counts when the count is not frozen by pause.
  assign count_en  = frame_tick & ~pse_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc1_d   = sc1_q;
    sc2_d   = sc2_q;
    win_d   = win_q;
    srv_d   = srv_q;
    pse_d   = pse_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_evt) begin
          state_d = SERVE;
          sc1_d   = '0;
          sc2_d   = '0;
          win_d   = 2'b00;
          srv_d   = 1'b0;
          cnt_d   = SERVE8;
        end
      end
      SERVE: begin
        if (pause_pulse) pse_d = ~pse_q;
        if (count_en) begin
          if (cnt_q == 8'd1) state_d = RALLY;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      RALLY: begin
        if (pause_pulse) pse_d = ~pse_q;
        if (miss_p1 || miss_p2) begin
          // Both at once is a replay: no score, direction unchanged.
          state_d = POINT;
          cnt_d   = HOLD8;
          if (miss_p2 && !miss_p1) begin
            if (sc1_q < WIN4) sc1_d = sc1_q + 4'd1;
            srv_d = 1'b0;
          end else if (miss_p1 && !miss_p2) begin
            if (sc2_q < WIN4) sc2_d = sc2_q + 4'd1;
            srv_d = 1'b1;
          end
        end
      end
      POINT: begin
        if (count_en) begin
          if (cnt_q == 8'd1) begin
            if (sc1_q == WIN4) begin
              win_d   = 2'b01;
              state_d = OVER;
            end else if (sc2_q == WIN4) begin
              win_d   = 2'b10;
              state_d = OVER;
            end else begin
              state_d = SERVE;
              cnt_d   = SERVE8;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE || state_d == POINT || state_d == OVER) pse_d = 1'b0;
    run_d = (state_d == RALLY) && !pse_d;
    rsp_d = (state_d == SERVE) && (state_q != SERVE);
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sc1_q   <= '0;
      sc2_q   <= '0;
      win_q   <= '0;
      srv_q   <= 1'b0;
      pse_q   <= 1'b0;
      run_q   <= 1'b0;
      rsp_q   <= 1'b0;
      st1_q   <= 1'b0;
      st2_q   <= 1'b0;
      st3_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc1_q   <= sc1_d;
      sc2_q   <= sc2_d;
      win_q   <= win_d;
      srv_q   <= srv_d;
      pse_q   <= pse_d;
      run_q   <= run_d;
      rsp_q   <= rsp_d;
      st1_q   <= start_btn;
      st2_q   <= st1_q;
      st3_q   <= st2_q;
    end
  end

  assign ball_run     = run_q;
  assign ball_respawn = rsp_q;
  assign serve_left   = srv_q;
  assign score_p1     = sc1_q;
  assign score_p2     = sc2_q;
  assign winner       = win_q;
  assign state_o      = state_q;
  assign paused       = pse_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller (WIN_SCORE=3, 60/90 frame holds).
module tb_pong_match_controller;

  logic       clk = 1'b0;
  logic       rst, frame_tick, start_btn, pause_pulse, miss_p1, miss_p2;
  logic       ball_run, ball_respawn, serve_left, paused;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] state_o;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  pong_match_controller #(
    .WIN_SCORE(3), .SERVE_DELAY_FRAMES(60), .POINT_HOLD_FRAMES(90)
  ) dut (
    .CLOCK_25(clk), .reset(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_pulse(pause_pulse), .miss_p1(miss_p1), .miss_p2(miss_p2),
    .ball_run(ball_run), .ball_respawn(ball_respawn), .serve_left(serve_left),
    .score_p1(score_p1), .score_p2(score_p2), .winner(winner),
    .state_o(state_o), .paused(paused)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick1();
      step();
    end
  endtask

  task automatic pulse_miss(input logic m1, input logic m2, input logic p);
    miss_p1 = m1; miss_p2 = m2; pause_pulse = p;
    step();
    miss_p1 = 1'b0; miss_p2 = 1'b0; pause_pulse = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 0; start_btn = 0; pause_pulse = 0; miss_p1 = 0; miss_p2 = 0;
    step(); step();
    chk("rst_state", state_o, 0);
    chk("rst_run", ball_run, 0);
    chk("rst_respawn", ball_respawn, 0);
    chk("rst_scores", {score_p1, score_p2}, 0);
    chk("rst_winner", winner, 0);
    chk("rst_paused", paused, 0);
    rst = 1'b0;
    step();

    // 1: start, respawn pulse, 60-frame serve delay
    start_btn = 1'b1;
    step(); step();
    chk("start_latency", state_o, 0);
    step();
    chk("serve_state", state_o, 1);
    chk("serve_respawn", ball_respawn, 1);
    chk("serve_left0", serve_left, 0);
    step();
    chk("respawn_one_cycle", ball_respawn, 0);
    step(); step();
    chk("held_btn_one_evt", ball_respawn, 0);
    ticks(59);
    chk("serve_59", state_o, 1);
    chk("serve_59_run", ball_run, 0);
    tick1();
    chk("rally_state", state_o, 2);
    chk("rally_run", ball_run, 1);
    step();

    // 2: single misses
    pulse_miss(1'b0, 1'b1, 1'b0);
    chk("p1_scores", score_p1, 1);
    chk("p1_serve_left", serve_left, 0);
    chk("point_state", state_o, 3);
    chk("point_run", ball_run, 0);
    ticks(89);
    chk("point_89", state_o, 3);
    tick1();
    chk("reserve_state", state_o, 1);
    chk("reserve_respawn", ball_respawn, 1);
    step();
    ticks(60);
    chk("rally2", state_o, 2);
    pulse_miss(1'b1, 1'b0, 1'b0);
    chk("p2_scores", score_p2, 1);
    chk("p2_serve_left", serve_left, 1);
    ticks(90);
    ticks(60);
    pulse_miss(1'b0, 1'b1, 1'b0);
    chk("p1_second", score_p1, 2);
    chk("serve_left_back", serve_left, 0);

    // 4: simultaneous misses replay at 2/1
    ticks(90);
    ticks(60);
    pulse_miss(1'b1, 1'b1, 1'b0);
    chk("dual_state", state_o, 3);
    chk("dual_scores", {score_p1, score_p2}, 8'h21);
    chk("dual_serve_left", serve_left, 0);

    // 5: pause
    ticks(90);
    ticks(60);
    pulse_miss(1'b0, 1'b0, 1'b1);
    chk("pause_run", ball_run, 0);
    chk("pause_flag", paused, 1);
    ticks(20);
    chk("pause_hold_state", state_o, 2);
    chk("pause_hold_run", ball_run, 0);
    pulse_miss(1'b0, 1'b0, 1'b1);
    chk("unpause_run", ball_run, 1);
    chk("unpause_flag", paused, 0);
    pulse_miss(1'b0, 1'b1, 1'b1);
    chk("pause_miss_state", state_o, 3);
    chk("pause_miss_paused", paused, 0);
    chk("p1_third", score_p1, 3);

    // 3: match over at WIN_SCORE=3
    ticks(89);
    chk("over_not_yet", winner, 0);
    tick1();
    chk("over_state", state_o, 4);
    chk("over_winner", winner, 1);
    chk("over_respawn", ball_respawn, 0);
    step();
    pulse_miss(1'b0, 1'b1, 1'b1);
    ticks(5);
    chk("over_score_held", score_p1, 3);
    chk("over_state_held", state_o, 4);
    chk("over_paused", paused, 0);
    start_btn = 1'b0;
    step(); step(); step();
    start_btn = 1'b1;
    step(); step(); step();
    chk("restart_state", state_o, 1);
    chk("restart_scores", {score_p1, score_p2}, 0);
    chk("restart_winner", winner, 0);
    chk("restart_respawn", ball_respawn, 1);
    step();

    // 6: async reset mid-serve (paused to make the reset visible)
    ticks(30);
    pulse_miss(1'b0, 1'b0, 1'b1);
    chk("pre_rst_paused", paused, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_state", state_o, 0);
    chk("async_paused", paused, 0);
    @(negedge clk);
    rst = 1'b0;
    start_btn = 1'b0;
    step();
    pulse_miss(1'b1, 1'b1, 1'b0);
    pulse_miss(1'b0, 1'b1, 1'b1);
    ticks(3);
    chk("idle_state", state_o, 0);
    chk("idle_scores", {score_p1, score_p2}, 0);
    chk("idle_respawn", ball_respawn, 0);
    chk("idle_paused", paused, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
